bp_sound_cmd_mailbox: RTL and testbench

Command mailbox between the Blue Print main CPU board and the sound board. It sits on the `sound_cmd`/`sound_cmd_wr` path. It captures each main-CPU command write into a small FIFO, presents the oldest command to the sound CPU, and raises a timed NMI pulse for every pending command. Writes are never silently merged: a command is either queued or flagged as an overflow.

---
 rtl/bp_snd_pkg.sv | 13 +
 rtl/bp_sound_cmd_mailbox_if.sv | 33 +++
 rtl/bp_cmd_fifo.sv | 50 +++++
 rtl/bp_sound_cmd_mailbox.sv | 111 +++++++++++
 tb/tb_bp_sound_cmd_mailbox.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bp_snd_pkg.sv
// Shared sound-board definitions: command width and NMI sequencer states.
// Reused by the mailbox and by the sound board proper.
package bp_snd_pkg;

    localparam int CMD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_RD
    } nmi_state_t;

endpackage

// File: rtl/bp_sound_cmd_mailbox_if.sv
// Main-CPU / sound-CPU side signals of the command mailbox.
// master = the CPU pair driving strobes, slave = the mailbox.
interface bp_sound_cmd_mailbox_if
    import bp_snd_pkg::*;
#(
    parameter int DEPTH = 4
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [CMD_W-1:0] cmd_data;
    logic             cmd_wr;
    logic             snd_rd;
    logic             ovf_clr;
    logic [CMD_W-1:0] snd_data;
    logic             snd_nmi_n;
    logic             cmd_pending;
    logic [LW-1:0]    fifo_level;
    logic             overflow;

    modport master (
        output cmd_data, cmd_wr, snd_rd, ovf_clr,
        input  snd_data, snd_nmi_n, cmd_pending,
        input  fifo_level, overflow
    );

    modport slave (
        input  cmd_data, cmd_wr, snd_rd, ovf_clr,
        output snd_data, snd_nmi_n, cmd_pending,
        output fifo_level, overflow
    );

endinterface

// File: rtl/bp_cmd_fifo.sv
// Small synchronous command FIFO; full/empty come from the level counter
// so pointer equality never has to disambiguate the two.
module bp_cmd_fifo
    import bp_snd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] din,
    output logic [CMD_W-1:0] head,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign head  = mem[rp];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/bp_sound_cmd_mailbox.sv
// Main-CPU to sound-CPU command mailbox: edge-detected writes into a FIFO,
// latch-style read data, sticky overflow and a timed NMI per command.
module bp_sound_cmd_mailbox
    import bp_snd_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NMI_WIDTH = 32
) (
    input  logic                   clk_49m,
    input  logic                   reset_n,
    bp_sound_cmd_mailbox_if.slave  bus
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = (NMI_WIDTH > 1) ? $clog2(NMI_WIDTH) : 1;

    logic             wr_q;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [LW-1:0]    level;
    logic [CMD_W-1:0] head;
    logic [CMD_W-1:0] last_q;
    logic             ovf_q;

    nmi_state_t       state;
    nmi_state_t       state_nxt;
    logic [CW-1:0]    nmi_cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             rd_seen;
    logic             rd_nxt;
    logic             nmi_q;

    assign push_req = bus.cmd_wr & ~wr_q;
    assign pop      = bus.snd_rd & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    bp_cmd_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk_49m),
        .rst_n (reset_n),
        .push  (push),
        .pop   (pop),
        .din   (bus.cmd_data),
        .head  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = nmi_cnt;
        rd_nxt    = rd_seen;
        unique case (state)
            IDLE: begin
                if (level != '0) begin
                    state_nxt = PULSE;
                    cnt_nxt   = CW'(NMI_WIDTH - 1);
                    rd_nxt    = 1'b0;
                end
            end
            PULSE: begin
                if (pop) rd_nxt = 1'b1;
                if (nmi_cnt == '0)
                    state_nxt = (rd_seen | pop) ? IDLE : WAIT_RD;
                else
                    cnt_nxt = nmi_cnt - CW'(1);
            end
            WAIT_RD: begin
                if (pop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_49m or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= 1'b0;
            last_q  <= '0;
            ovf_q   <= 1'b0;
            state   <= IDLE;
            nmi_cnt <= '0;
            rd_seen <= 1'b0;
            nmi_q   <= 1'b1;
        end else begin
            wr_q    <= bus.cmd_wr;
            if (pop) last_q <= head;
            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
            state   <= state_nxt;
            nmi_cnt <= cnt_nxt;
            rd_seen <= rd_nxt;
            nmi_q   <= (state_nxt != PULSE);
        end
    end

    assign bus.snd_data    = empty ? last_q : head;
    assign bus.snd_nmi_n   = nmi_q;
    assign bus.cmd_pending = ~empty;
    assign bus.fifo_level  = level;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_bp_sound_cmd_mailbox.sv
// Bench for bp_sound_cmd_mailbox: directed scenarios plus random traffic
// checked against a queue-based model of the mailbox.
module tb_bp_sound_cmd_mailbox;
    import bp_snd_pkg::*;

    localparam int DEPTH = 4;
    localparam int NMI_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bp_sound_cmd_mailbox_if #(.DEPTH(DEPTH)) bus ();

    bp_sound_cmd_mailbox #(
        .DEPTH     (DEPTH),
        .NMI_WIDTH (NMI_W)
    ) dut (
        .clk_49m (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] m_last;
    logic       m_ovf;
    logic       m_wr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = 8'h00;
        m_ovf  = 1'b0;
        m_wr   = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [7:0] d,
                              input logic rd, input logic clr);
        bit req, pop, full, dropped;
        req     = wr && !m_wr;
        full    = (q.size() == DEPTH);
        pop     = rd && (q.size() != 0);
        dropped = req && full && !pop;
        if (pop) m_last = q.pop_front();
        if (req && !dropped) q.push_back(d);
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_wr = wr;
    endtask

    task automatic check_outs(input string tag);
        logic [7:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : m_last;
        chk({tag, ".data"}, 32'(bus.snd_data), 32'(exp_data));
        chk({tag, ".level"}, 32'(bus.fifo_level), q.size());
        chk({tag, ".pend"}, 32'(bus.cmd_pending), 32'(q.size() != 0));
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic cyc(input logic wr, input logic [7:0] d, input logic rd,
                       input logic clr, input string tag);
        bus.cmd_wr   = wr;
        bus.cmd_data = d;
        bus.snd_rd   = rd;
        bus.ovf_clr  = clr;
        @(posedge clk);
        model_step(wr, d, rd, clr);
        #1;
        check_outs(tag);
    endtask

    task automatic do_reset();
        bus.cmd_wr   = 1'b0;
        bus.cmd_data = 8'h00;
        bus.snd_rd   = 1'b0;
        bus.ovf_clr  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic single_cmd(input logic [7:0] d, input string tag);
        cyc(1'b1, d, 1'b0, 1'b0, {tag, ".wr"});
        chk({tag, ".nmi_n1"}, 32'(bus.snd_nmi_n), 1);
        for (int i = 0; i < NMI_W; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, {tag, ".pulse"});
            chk({tag, ".nmi_low"}, 32'(bus.snd_nmi_n), 0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, {tag, ".end"});
        chk({tag, ".nmi_end"}, 32'(bus.snd_nmi_n), 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, {tag, ".rd"});
        chk({tag, ".rd_data"}, 32'(bus.snd_data), 32'(d));
        chk({tag, ".rd_level"}, 32'(bus.fifo_level), 0);
        repeat (3) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, {tag, ".idle"});
            chk({tag, ".nmi_idle"}, 32'(bus.snd_nmi_n), 1);
        end
    endtask

    initial begin
        bus.cmd_wr   = 1'b0;
        bus.cmd_data = 8'h00;
        bus.snd_rd   = 1'b0;
        bus.ovf_clr  = 1'b0;
        model_reset();

        do_reset();
        check_outs("reset");
        chk("reset.nmi_n", 32'(bus.snd_nmi_n), 1);

        single_cmd(8'h5A, "single");

        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, "ovf.wr");
            cyc(1'b0, 8'h00, 1'b0, 1'b0, "ovf.gap");
        end
        chk("ovf.level4", 32'(bus.fifo_level), 4);
        chk("ovf.flag", 32'(bus.overflow), 1);
        for (int i = 1; i <= 6; i++) begin
            chk("ovf.rd_val", 32'(bus.snd_data), (i > 4) ? 4 : i);
            cyc(1'b0, 8'h00, 1'b1, 1'b0, "ovf.rd");
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "ovf.clr");
        chk("ovf.cleared", 32'(bus.overflow), 0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "full.wr");
            cyc(1'b0, 8'h00, 1'b0, 1'b0, "full.gap");
        end
        cyc(1'b1, 8'hAA, 1'b1, 1'b0, "full.both");
        chk("full.level", 32'(bus.fifo_level), 4);
        chk("full.noovf", 32'(bus.overflow), 0);
        chk("full.head", 32'(bus.snd_data), 32'h11);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "full.gap");
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0, "full.drain");
        chk("full.tail", 32'(bus.snd_data), 32'hAA);

        do_reset();
        repeat (100) cyc(1'b1, 8'h77, 1'b0, 1'b0, "held");
        chk("held.level", 32'(bus.fifo_level), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "held.rel");
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "held.rd");
        repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0, "held.idle");
        cyc(1'b1, 8'h33, 1'b0, 1'b0, "rdp.wr");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "rdp.p1");
        chk("rdp.nmi_p1", 32'(bus.snd_nmi_n), 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "rdp.rd");
        chk("rdp.nmi_p2", 32'(bus.snd_nmi_n), 0);
        for (int i = 2; i < NMI_W; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, "rdp.pulse");
            chk("rdp.nmi_low", 32'(bus.snd_nmi_n), 0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "rdp.end");
        chk("rdp.nmi_end", 32'(bus.snd_nmi_n), 1);
        single_cmd(8'h44, "rdp.next");

        do_reset();
        cyc(1'b1, 8'h5A, 1'b0, 1'b0, "mid.wr");
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, "mid.pulse");
            chk("mid.nmi_low", 32'(bus.snd_nmi_n), 0);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("mid.rst");
        chk("mid.nmi_rel", 32'(bus.snd_nmi_n), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        single_cmd(8'h5A, "mid.after");

        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 7) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
